seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed 4-digit seven-segment scan driver that consumes the four hex digit buses produced by the rotating-digit display block. It turns them into common-anode digit enables and segment lines for the board display. All digit values are captured once per frame, so a rotation or key update mid-scan never produces a torn frame. Optional leading-zero blanking and per-digit decimal points are included.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range 4 to 2^20.
- BLANK_CYC, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting); legal range 1 to SCAN_DIV-1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- d3  in  4  most-significant digit value, 0x0–0xF.
- d2  in  4  digit 2.
- d1  in  4  digit 1.
- d0  in  4  least-significant digit value.
- dp_in  in  4  decimal point request; bit i belongs to digit i.
- lzb_en  in  1  leading-zero blanking enable.
- disp_en  in  1  display enable; 0 forces all anodes off while scanning continues.
- an  out  4  digit enables, active-low; bit i drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when a new frame snapshot takes effect.

## Operation
- Counters:
  - cnt runs 0..SCAN_DIV-1 and wraps.
  - slot (2 bits) increments when cnt wraps, scanning 0→1→2→3→0.
- Snapshot: at the clock edge where (slot, cnt) = (0, 0), register d3..d0, dp_in and lzb_en. All decode for the frame uses only these registered values.
- Per cycle, from the current (slot, cnt):
  - **Blanked.** The slot is blanked if any of these hold:
    - cnt < BLANK_CYC;
    - disp_en = 0;
    - the slot's digit is a suppressed leading zero.
  - Blanked result: an = 4'b1111, seg = 7'b1111111, dp = 1.
  - **Otherwise:**
    - an has only bit slot low;
    - seg = hex decode of snapshot digit[slot];
    - dp = ~snapshot dp_in[slot].
- Leading-zero suppression, applied only when the snapshot lzb_en = 1:
  - digit 3 is suppressed if it is 0;
  - digit 2 is suppressed if digits 3 and 2 are 0;
  - digit 1 is suppressed if digits 3, 2 and 1 are 0;
  - digit 0 is never suppressed.
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- disp_en is sampled live, not snapshotted, so it blanks immediately.

## Timing
- Reset values (asynchronous, while reset = 0):
  - cnt = 0, slot = 0, snapshot = 0;
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
- Outputs are registered with one cycle of latency: the outputs in cycle t+1 reflect (slot, cnt) and the snapshot as of the edge that ends cycle t.
- Because BLANK_CYC ≥ 1, slot 0 always starts blanked. The new snapshot is therefore stable before any anode is driven.
- frame_tick is high for exactly one cycle: the cycle immediately after the snapshot edge. The period is 4·SCAN_DIV cycles.
- In each slot:
  - anode-off time is BLANK_CYC cycles;
  - anode-on time is SCAN_DIV − BLANK_CYC cycles;
  - frame period is 4·SCAN_DIV.
- Input changes between snapshot edges have no effect until the next frame.
- After reset is released:
  - the first rising edge is the snapshot edge;
  - the first frame_tick occurs in the following cycle.
- Reset asserted mid-slot or mid-frame immediately forces the reset values. Scanning restarts from slot 0 with a fresh snapshot.
- Wrap: slot 3 → slot 0 at the cnt wrap, and that edge is also the snapshot edge.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2.
- Reset held low with random inputs -> an=1111, seg=1111111, dp=1, frame_tick=0 on every cycle; asserting reset mid-slot 2 returns all outputs to these values at once.
- d3..d0=1,2,3,4, lzb_en=0, disp_en=1 -> per slot, 2 cycles with an=1111, then 6 cycles with:
  - an=1110, seg=0011001 (digit 0);
  - an=1101, seg=0110000 (digit 1);
  - an=1011, seg=0100100 (digit 2);
  - an=0111, seg=1111001 (digit 3);
  - frame_tick every 32 cycles.
- Change d0 from 4 to F during slot 1 -> slot 0 of the current frame stays 0011001; seg=0001110 appears only in slot 0 after the next frame_tick.
- lzb_en=1, d=0,0,0,7 -> only an[0] is ever low, with seg=1111000. d=0,0,0,0 -> only digit 0 lit, seg=1000000. d=0,5,0,0 -> digits 2, 1 and 0 lit; digit 3 stays dark.
- dp_in=0100 -> dp=0 only in the active window of slot 2, otherwise dp=1.
- disp_en dropped mid-slot 1 -> an=1111 one cycle later; cnt and slot keep running, and frame_tick is still at the 32-cycle cadence.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with per-frame snapshot, leading-zero blanking and decimal points.
// Outputs are registered and lag the scan counters by one cycle. There is no backpressure; the scan free-runs.
module seg7_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   input  logic       lzb_en,
   input  logic       disp_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   logic [CW-1:0]   cnt;
   logic [1:0]      slot;
   logic            snap_edge;

   logic [3:0][3:0] snap_dig;
   logic [3:0]      snap_dp;
   logic            snap_lzb;

   logic [3:0]      cur_dig;
   logic [3:0]      lz;
   logic            blank;
   logic [3:0]      an_nxt;
   logic [6:0]      seg_nxt;
   logic            dp_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign snap_edge = (slot == 2'd0) && (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         slot <= 2'd0;
      end else if (cnt == CNT_MAX) begin
         cnt  <= '0;
         slot <= slot + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Slot 0 always opens blanked, so the new snapshot settles before any anode lights.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_dig <= '0;
         snap_dp  <= '0;
         snap_lzb <= 1'b0;
      end else if (snap_edge) begin
         snap_dig <= {d3, d2, d1, d0};
         snap_dp  <= dp_in;
         snap_lzb <= lzb_en;
      end
   end

   always_comb begin
      cur_dig = snap_dig[slot];
      lz[3]   = (snap_dig[3] == 4'h0);
      lz[2]   = lz[3] && (snap_dig[2] == 4'h0);
      lz[1]   = lz[2] && (snap_dig[1] == 4'h0);
      lz[0]   = 1'b0;
      blank   = (cnt < BLANK_END) || !disp_en || (snap_lzb && lz[slot]);
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
      dp_nxt  = 1'b1;
      if (!blank) begin
         an_nxt[slot] = 1'b0;
         seg_nxt      = hex7(cur_dig);
         dp_nxt       = ~snap_dp[slot];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_tick <= snap_edge;
      end
   end

endmodule
